// File: rtl/mseq_checker.sv
// mseq_checker: self-synchronising m-sequence checker with lock detection and BER counters.
// Optional complemented-stream lock detection is enabled by defining MSEQ_INV_DETECT_EN.
module mseq_checker #(
   parameter int unsigned  N        = 4,
   parameter logic [N-1:0] POLY     = 4'b1100,
   parameter int unsigned  LOCK_CNT = 8,
   parameter int unsigned  WIN      = 64,
   parameter int unsigned  LOSS_TH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_in,
   input  logic        bit_en,
   input  logic        clr_cnt,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_cnt,
   output logic [23:0] bit_cnt,
   output logic        inverted
);
   localparam int unsigned HW = $clog2(N + 1);
   localparam int unsigned MW = $clog2(LOCK_CNT + 1);
   localparam int unsigned WW = $clog2(WIN + 1);
   localparam int unsigned EW = $clog2(LOSS_TH + 1);

   typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

   state_t        r_state, w_state_nx;
   logic [N-1:0]  r_h, w_h_nx, w_h_sh;
   logic [HW-1:0] r_hunt_cnt, w_hunt_nx;
   logic [MW-1:0] r_match_cnt, w_match_nx;
   logic [WW-1:0] r_win_cnt, w_win_nx;
   logic [EW-1:0] r_win_err, w_werr_nx, w_werr_inc;
   logic          r_err_pulse;
   logic [15:0]   r_err_cnt;
   logic [23:0]   r_bit_cnt;
   logic          w_p, w_t_ok, w_any_ok, w_inv;
   logic          w_err_bit, w_cnt_bit;

   assign w_p        = ^(r_h & POLY);
   assign w_h_sh     = {r_h[N-2:0], bit_in};
   assign w_werr_inc = (r_win_err != EW'(LOSS_TH)) ? r_win_err + 1'b1 : r_win_err;

`ifdef MSEQ_INV_DETECT_EN
   // Complement path history is seeded with ~h and fed ~bit_in, so it always holds true-polarity bits.
   logic [N-1:0]  r_hc, w_hc_nx;
   logic [MW-1:0] r_mc, w_mc_nx;
   logic          r_alive_t, r_alive_c, w_alive_t_nx, w_alive_c_nx;
   logic          r_inv, w_inv_nx, w_c_ok;

   assign w_t_ok   = r_alive_t & (bit_in == w_p);
   assign w_c_ok   = r_alive_c & (bit_in != ^(r_hc & POLY));
   assign w_any_ok = w_t_ok | w_c_ok;
   assign w_inv    = r_inv;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hc      <= '0;
         r_mc      <= '0;
         r_alive_t <= 1'b0;
         r_alive_c <= 1'b0;
         r_inv     <= 1'b0;
      end else begin
         r_hc      <= w_hc_nx;
         r_mc      <= w_mc_nx;
         r_alive_t <= w_alive_t_nx;
         r_alive_c <= w_alive_c_nx;
         r_inv     <= w_inv_nx;
      end
   end
`else
   assign w_t_ok   = (bit_in == w_p);
   assign w_any_ok = w_t_ok;
   assign w_inv    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= HUNT;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_h_nx     = r_h;
      w_hunt_nx  = r_hunt_cnt;
      w_match_nx = r_match_cnt;
      w_win_nx   = r_win_cnt;
      w_werr_nx  = r_win_err;
      w_err_bit  = 1'b0;
      w_cnt_bit  = 1'b0;
`ifdef MSEQ_INV_DETECT_EN
      w_hc_nx      = r_hc;
      w_mc_nx      = r_mc;
      w_alive_t_nx = r_alive_t;
      w_alive_c_nx = r_alive_c;
      w_inv_nx     = r_inv;
`endif
      if (bit_en) begin
         unique case (r_state)
            HUNT: begin
               w_h_nx = w_h_sh;
               if (r_hunt_cnt == HW'(N - 1)) begin
                  w_hunt_nx = '0;
                  if (w_h_sh != '0) begin
                     w_state_nx = CHECK;
                     w_match_nx = '0;
`ifdef MSEQ_INV_DETECT_EN
                     w_hc_nx      = ~w_h_sh;
                     w_mc_nx      = '0;
                     w_alive_t_nx = 1'b1;
                     w_alive_c_nx = 1'b1;
`endif
                  end
               end else begin
                  w_hunt_nx = r_hunt_cnt + 1'b1;
               end
            end
            CHECK: begin
               if (!w_any_ok) begin
                  w_state_nx = HUNT;
                  w_hunt_nx  = '0;
                  w_match_nx = '0;
               end else begin
                  if (w_t_ok) begin
                     w_h_nx     = w_h_sh;
                     w_match_nx = r_match_cnt + 1'b1;
                  end
`ifdef MSEQ_INV_DETECT_EN
                  w_alive_t_nx = w_t_ok;
                  w_alive_c_nx = w_c_ok;
                  if (w_c_ok) begin
                     w_hc_nx = {r_hc[N-2:0], ~bit_in};
                     w_mc_nx = r_mc + 1'b1;
                  end
                  if (w_c_ok && r_mc == MW'(LOCK_CNT - 1) &&
                      !(w_t_ok && r_match_cnt == MW'(LOCK_CNT - 1))) begin
                     w_state_nx = LOCKED;
                     w_inv_nx   = 1'b1;
                     w_h_nx     = {r_hc[N-2:0], ~bit_in};
                  end
`endif
                  if (w_t_ok && r_match_cnt == MW'(LOCK_CNT - 1)) w_state_nx = LOCKED;
               end
            end
            LOCKED: begin
               w_h_nx    = {r_h[N-2:0], w_p};
               w_cnt_bit = 1'b1;
               w_err_bit = ((bit_in ^ w_inv) != w_p);
               if (w_err_bit) w_werr_nx = w_werr_inc;
               if (r_win_cnt == WW'(WIN - 1)) begin
                  w_win_nx  = '0;
                  w_werr_nx = '0;
                  if ((w_err_bit ? w_werr_inc : r_win_err) >= EW'(LOSS_TH)) begin
                     w_state_nx = HUNT;
                     w_hunt_nx  = '0;
                     w_match_nx = '0;
`ifdef MSEQ_INV_DETECT_EN
                     w_inv_nx   = 1'b0;
`endif
                  end
               end else begin
                  w_win_nx = r_win_cnt + 1'b1;
               end
            end
            default: w_state_nx = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h         <= '0;
         r_hunt_cnt  <= '0;
         r_match_cnt <= '0;
         r_win_cnt   <= '0;
         r_win_err   <= '0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
         r_bit_cnt   <= '0;
      end else begin
         r_h         <= w_h_nx;
         r_hunt_cnt  <= w_hunt_nx;
         r_match_cnt <= w_match_nx;
         r_win_cnt   <= w_win_nx;
         r_win_err   <= w_werr_nx;
         r_err_pulse <= w_err_bit;
         // Clear wins over a same-cycle increment; the pulse is unaffected.
         if (clr_cnt) begin
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
         end else begin
            if (w_err_bit && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (w_cnt_bit && r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      locked    = (r_state == LOCKED);
      err_pulse = r_err_pulse;
      err_cnt   = r_err_cnt;
      bit_cnt   = r_bit_cnt;
      inverted  = w_inv;
   end
endmodule

// File: tb/tb_mseq_checker.sv
// Directed testbench for mseq_checker: lock, error counting, loss/relock, clear, reset, lock-up and inverted stream.
module tb_mseq_checker;
   logic        clk = 1'b0;
   logic        rst, bit_in, bit_en, clr_cnt;
   logic        locked, err_pulse, inverted;
   logic [15:0] err_cnt;
   logic [23:0] bit_cnt;
   logic [3:0]  g;
   logic        b;
   int          total = 0;
   int          bad   = 0;

   mseq_checker #(.N(4), .POLY(4'b1100), .LOCK_CNT(8), .WIN(64), .LOSS_TH(8)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clr_cnt(clr_cnt),
      .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt),
      .inverted(inverted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference generator for x^4+x^3+1: new bit = h[3]^h[2], h[0] newest.
   task automatic gen(output logic ob);
      ob = g[3] ^ g[2];
      g  = {g[2:0], ob};
   endtask

   task automatic send(input logic vb, input logic clr);
      repeat (3) @(negedge clk);
      bit_in  = vb;
      bit_en  = 1'b1;
      clr_cnt = clr;
      @(negedge clk);
      bit_en  = 1'b0;
      clr_cnt = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bit_in = 1'b0; bit_en = 1'b0; clr_cnt = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_locked", locked, 0);
      chk("rst_pulse", err_pulse, 0);
      chk("rst_errcnt", err_cnt, 0);
      chk("rst_bitcnt", bit_cnt, 0);
      chk("rst_inv", inverted, 0);
      rst = 1'b0;

      // Clean lock from seed 0001
      g = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         gen(b); send(b, 1'b0);
         if (i == 10) chk("lock_early", locked, 0);
      end
      chk("lock_at12", locked, 1);
      chk("lock_errcnt", err_cnt, 0);
      chk("lock_bitcnt", bit_cnt, 0);
      chk("lock_inv", inverted, 0);

      // 150 locked bits, single flip at index 20
      for (int k = 0; k < 150; k++) begin
         gen(b); send(b ^ (k == 20), 1'b0);
         chk("a_pulse", err_pulse, (k == 20));
         if (k == 20) begin
            chk("a_errcnt1", err_cnt, 1);
            @(negedge clk);
            chk("a_pulse_1clk", err_pulse, 0);
         end
      end
      chk("a_bitcnt150", bit_cnt, 150);
      chk("a_errcnt", err_cnt, 1);
      chk("a_locked", locked, 1);

      // Standalone clear, then 8 errors in window [128..191]
      @(negedge clk); clr_cnt = 1'b1;
      @(negedge clk); clr_cnt = 1'b0;
      chk("clr_errcnt", err_cnt, 0);
      chk("clr_bitcnt", bit_cnt, 0);
      chk("clr_locked", locked, 1);
      for (int k = 150; k < 192; k++) begin
         gen(b); send(b ^ (k >= 170 && k <= 177), 1'b0);
         chk("b_locked", locked, (k < 191));
         chk("b_pulse", err_pulse, (k >= 170 && k <= 177));
      end
      chk("b_errcnt", err_cnt, 8);
      chk("b_bitcnt", bit_cnt, 42);
      for (int i = 0; i < 12; i++) begin
         gen(b); send(b, 1'b0);
         chk("relock", locked, (i == 11));
      end
      chk("relock_errcnt", err_cnt, 8);
      chk("relock_bitcnt", bit_cnt, 42);

      // Clear coincident with an errored bit
      for (int i = 0; i < 5; i++) begin gen(b); send(b, 1'b0); end
      gen(b); send(~b, 1'b1);
      chk("c_pulse", err_pulse, 1);
      chk("c_errcnt", err_cnt, 0);
      chk("c_bitcnt", bit_cnt, 0);
      chk("c_locked", locked, 1);
      gen(b); send(b, 1'b0);
      chk("c_pulse_next", err_pulse, 0);
      chk("c_bitcnt_next", bit_cnt, 1);
      chk("c_errcnt_next", err_cnt, 0);

      // Reset mid-LOCKED with an errored strobe present
      gen(b);
      @(negedge clk); rst = 1'b1; bit_en = 1'b1; bit_in = ~b;
      @(negedge clk);
      chk("mr_locked", locked, 0);
      chk("mr_pulse", err_pulse, 0);
      chk("mr_errcnt", err_cnt, 0);
      chk("mr_bitcnt", bit_cnt, 0);
      chk("mr_inv", inverted, 0);
      rst = 1'b0; bit_en = 1'b0;

      // All-zero stream must not lock, then a valid stream locks after 12 bits
      for (int i = 0; i < 20; i++) begin
         send(1'b0, 1'b0);
         chk("zero_locked", locked, 0);
      end
      g = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         gen(b); send(b, 1'b0);
         chk("z_relock", locked, (i == 11));
      end

      // Complemented stream
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      g = 4'b0001;
`ifdef MSEQ_INV_DETECT_EN
      for (int i = 0; i < 12; i++) begin
         gen(b); send(~b, 1'b0);
         chk("inv_lock", locked, (i == 11));
      end
      chk("inv_flag", inverted, 1);
      chk("inv_errcnt0", err_cnt, 0);
      for (int i = 0; i < 20; i++) begin
         gen(b); send(~b, 1'b0);
         chk("inv_pulse", err_pulse, 0);
      end
      chk("inv_errcnt", err_cnt, 0);
      chk("inv_bitcnt", bit_cnt, 20);
`else
      for (int i = 0; i < 40; i++) begin
         gen(b); send(~b, 1'b0);
         chk("noinv_locked", locked, 0);
      end
      chk("noinv_flag", inverted, 0);
      chk("noinv_errcnt", err_cnt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
